serializador_piso: RTL and testbench

//   Parallel-in/serial-out transmitter; the sending end of the team's serial-in shift registers.

---
 rtl/serializador_piso.sv | 116 +++++++++++
 tb/tb_serializador_piso.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serializador_piso.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on load/ready and sends one bit per clock.
// Latency: first bit is registered on the accepting edge; done pulses one edge after the last bit.
// Backpressure: ready is low from the accepting edge until the edge after done; load is ignored meanwhile.
module serializador_piso #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  // The shift register keeps the bit currently on 'out' at its output end, so
  // the bit to send next is always the one adjacent to that end.
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // Select bit order: output end is bit 0 for LSB-first, bit WIDTH-1 for MSB-first.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit     = data_in[WIDTH-1];
      next_bit      = shreg_q[WIDTH-2];
      shreg_shifted = shreg_q << 1;
    end else begin
      first_bit     = data_in[0];
      next_bit      = shreg_q[1];
      shreg_shifted = shreg_q >> 1;
    end
  end

  // Next-state and next-output logic; outputs default to idle values each cycle.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    out_d       = 1'b0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d     = data_in;
          count_d     = '0;
          out_d       = first_bit;
          out_valid_d = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (count_q == LAST_CNT) begin
          // Last bit has been on the line for one cycle; close the frame.
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          shreg_d     = shreg_shifted;
          count_d     = count_q + CNT_W'(1);
          out_d       = next_bit;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serializador_piso.sv
// Bench for serializador_piso: a 4-bit LSB-first and an 8-bit MSB-first instance side by side.
// A word-level model queues expected (cycle, bit) and done events; a monitor pops and compares.
// Directed frames first, then random load/data/reset traffic.
module tb_serializador_piso;

  logic       clock = 1'b0;
  logic       reset;
  logic       ld [2];
  logic [7:0] din;
  logic       rdy [2];
  logic       so  [2];
  logic       sv  [2];
  logic       dn  [2];

  always #5 clock = ~clock;

  serializador_piso #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_a (
    .clock(clock), .reset(reset), .data_in(din[3:0]), .load(ld[0]),
    .ready(rdy[0]), .out(so[0]), .out_valid(sv[0]), .done(dn[0])
  );

  serializador_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_b (
    .clock(clock), .reset(reset), .data_in(din), .load(ld[1]),
    .ready(rdy[1]), .out(so[1]), .out_valid(sv[1]), .done(dn[1])
  );

  function automatic int wid(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  // Expected events are tagged with the index of the clock edge after which
  // they must be visible; bits are encoded as edge*2 + bit.
  int cyc = 0;
  int busy [2];
  int bq [2][$];
  int dq [2][$];
  bit stop = 1'b0;

  // Word-level model: an accepted word occupies the transmitter for WIDTH
  // bit cycles plus the done cycle; its bits and its done pulse are queued.
  always @(posedge clock) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        bq[i].delete();
        dq[i].delete();
        busy[i] = 0;
      end else if (busy[i] == 0 && ld[i]) begin
        for (int j = 0; j < wid(i); j++) begin
          bq[i].push_back((cyc + j) * 2 + int'(din[(i == 1) ? (7 - j) : j]));
        end
        dq[i].push_back(cyc + wid(i));
        busy[i] = wid(i) + 1;
      end else if (busy[i] > 0) begin
        busy[i] = busy[i] - 1;
      end
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d edge %0d: got %0d, expected %0d", name, i, cyc, act, exp);
    end
  endtask

  // Monitor: samples away from the rising edge and on reset assertion.
  initial begin
    int e;
    while (!stop) begin
      @(negedge clock or posedge reset);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (reset) begin
          chk("reset_outputs{out,valid,done,ready}", i, int'({so[i], sv[i], dn[i], rdy[i]}), 1);
        end else begin
          chk("ready", i, int'(rdy[i]), int'(busy[i] == 0));
          if (sv[i]) begin
            if (bq[i].size() == 0) begin
              chk("bit_unexpected(edge*2+bit)", i, cyc * 2 + int'(so[i]), -1);
            end else begin
              e = bq[i].pop_front();
              chk("bit(edge*2+bit)", i, cyc * 2 + int'(so[i]), e);
            end
          end else begin
            chk("out_idle", i, int'(so[i]), 0);
            if (bq[i].size() != 0 && bq[i][0] / 2 <= cyc) begin
              e = bq[i].pop_front();
              chk("bit_missing(edge*2+bit)", i, -1, e);
            end
          end
          if (dn[i]) begin
            if (dq[i].size() == 0) begin
              chk("done_unexpected(edge)", i, cyc, -1);
            end else begin
              e = dq[i].pop_front();
              chk("done(edge)", i, cyc, e);
            end
          end else if (dq[i].size() != 0 && dq[i][0] <= cyc) begin
            e = dq[i].pop_front();
            chk("done_missing(edge)", i, -1, e);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      chk("bits_left", i, bq[i].size(), 0);
      chk("dones_left", i, dq[i].size(), 0);
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ld(input logic v);
    ld[0] = v;
    ld[1] = v;
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    set_ld(1'b0);
    din = 8'h00;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Single word 1011 (dut_b sees 0x0B).
    din = 8'h0B;
    set_ld(1'b1);
    step();
    set_ld(1'b0);
    repeat (12) step();

    // load held high: 0110 accepted, then 1001 accepted after the bubble.
    din = 8'h06;
    set_ld(1'b1);
    step();
    din = 8'h09;
    repeat (8) step();
    set_ld(1'b0);
    repeat (12) step();

    // load pulsed with zero data mid-frame must be ignored.
    din = 8'h0F;
    set_ld(1'b1);
    step();
    set_ld(1'b0);
    step();
    step();
    din = 8'h00;
    set_ld(1'b1);
    step();
    set_ld(1'b0);
    repeat (12) step();

    // Reset after two bits of 1111, then a clean 0101 word.
    din = 8'hFF;
    set_ld(1'b1);
    step();
    set_ld(1'b0);
    step();
    #2;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    din = 8'h05;
    set_ld(1'b1);
    step();
    set_ld(1'b0);
    repeat (12) step();

    // 0xA5 on the MSB-first instance.
    din = 8'hA5;
    set_ld(1'b1);
    step();
    set_ld(1'b0);
    repeat (14) step();

    // Random traffic with occasional resets.
    repeat (2000) begin
      din   = 8'($urandom);
      ld[0] = ($urandom_range(0, 2) == 0);
      ld[1] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end

    set_ld(1'b0);
    repeat (20) step();
    stop = 1'b1;
  end

endmodule
